// File: rtl/bool_check_pkg.sv
// Shared types for the boolean-pair checker: bool alias, FSM states, truth constants
// and the per-transfer error predicate.
package bool_check_pkg;

    typedef logic bool;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam bool TRUE  = 1'b1;
    localparam bool FALSE = 1'b0;

    // A pair is good only when it is exactly (TRUE, FALSE).
    function automatic bool pair_is_bad(input bool t, input bool f);
        return !((t == TRUE) && (f == FALSE));
    endfunction

endpackage

// File: rtl/bool_pair_checker_if.sv
// Boolean-pair transfer bundle: the source drives the pair and in_valid,
// and the checker drives in_ready.
interface bool_pair_checker_if;
    import bool_check_pkg::*;

    bool in_valid;
    bool in_ready;
    bool true_val;
    bool false_val;

    modport master (output in_valid, output true_val, output false_val, input in_ready);
    modport slave  (input in_valid, input true_val, input false_val, output in_ready);

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr has priority over inc.
// One-cycle update latency, no handshake.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/bool_pair_checker.sv
// Checks SAMPLES accepted boolean pairs per run and reports pass, a saturating
// error count and the first failing index; done pulses the cycle after the last transfer.
module bool_pair_checker
    import bool_check_pkg::*;
#(
    parameter int SAMPLES = 16,
    parameter int CNT_W   = 5,
    parameter int ERR_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    bool_pair_checker_if.slave   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [CNT_W-1:0]     first_err_idx
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES - 1);
    localparam logic [CNT_W-1:0] NONE_IDX = CNT_W'(SAMPLES);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] idx;
    logic             run_start;
    logic             xfer;
    logic             bad;
    logic             last;
    logic             err_inc;

    // Acceptance depends only on state, so in_valid never reaches in_ready.
    assign run_start = (state == IDLE) && start;
    assign xfer      = (state == RUN) && bus.in_valid;
    assign bad       = pair_is_bad(bus.true_val, bus.false_val);
    assign last      = (idx == LAST_IDX);
    assign err_inc   = xfer && bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.in_ready = FALSE;
        busy         = FALSE;
        done         = FALSE;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.in_ready = TRUE;
                busy         = TRUE;
                if (xfer && last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = TRUE;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx           <= '0;
            first_err_idx <= '0;
            pass          <= FALSE;
        end else if (run_start) begin
            idx           <= '0;
            first_err_idx <= NONE_IDX;
            pass          <= FALSE;
        end else if (xfer) begin
            idx <= idx + CNT_W'(1);
            if (bad && (first_err_idx == NONE_IDX)) begin
                first_err_idx <= idx;
            end
            // Fold in the final transfer so pass is valid in the DONE cycle.
            if (last) begin
                pass <= !bad && (err_count == '0);
            end
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (run_start),
        .inc (err_inc),
        .q   (err_count)
    );

endmodule

// File: tb/tb_bool_pair_checker.sv
// Directed bench for bool_pair_checker: normal runs, errors, gaps, saturation,
// mid-run reset, ignored starts and a single-sample configuration.
module tb_bool_pair_checker;
    import bool_check_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_passed = 0;

    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic       busy_a, done_a, pass_a;
    logic       busy_b, done_b, pass_b;
    logic       busy_c, done_c, pass_c;
    logic [7:0] err_a;
    logic [1:0] err_b;
    logic [7:0] err_c;
    logic [4:0] fidx_a;
    logic [4:0] fidx_b;
    logic [0:0] fidx_c;

    bool_pair_checker_if bus_a ();
    bool_pair_checker_if bus_b ();
    bool_pair_checker_if bus_c ();

    bool_pair_checker #(.SAMPLES(16), .CNT_W(5), .ERR_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bus(bus_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .err_count(err_a), .first_err_idx(fidx_a)
    );

    bool_pair_checker #(.SAMPLES(16), .CNT_W(5), .ERR_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bus(bus_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .err_count(err_b), .first_err_idx(fidx_b)
    );

    bool_pair_checker #(.SAMPLES(1), .CNT_W(1), .ERR_W(8)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .bus(bus_c), .busy(busy_c),
        .done(done_c), .pass(pass_c), .err_count(err_c), .first_err_idx(fidx_c)
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp) n_passed++;
        else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Runs dut_a from the current cycle; returns the cycle index (start cycle = 0)
    // at which done was seen, the cycle of the last transfer and the transfer count.
    task automatic run_a(input logic [15:0] tv, input logic [15:0] fv, input int gap,
                         input int start_pulse_cyc,
                         output int done_cyc, output int last_xfer, output int xfers);
        int  cyc;
        logic vld;
        start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        cyc = 1; xfers = 0; last_xfer = 0; done_cyc = 0;
        check("run_start_pass_clr", pass_a, 0);
        check("run_start_err_clr", err_a, 0);
        check("run_start_fidx_none", fidx_a, 16);
        while (cyc <= 200 && done_cyc == 0) begin
            if (done_a) begin
                done_cyc = cyc;
            end else begin
                vld = ((cyc - 1) % gap == 0) && (xfers < 16);
                start_a = (cyc == start_pulse_cyc);
                bus_a.in_valid  = vld;
                bus_a.true_val  = vld ? tv[xfers[3:0]] : 1'b0;
                bus_a.false_val = vld ? fv[xfers[3:0]] : 1'b1;
                @(negedge clk);
                if (bus_a.in_valid && bus_a.in_ready) begin
                    xfers++;
                    last_xfer = cyc;
                end
                @(posedge clk); #1 cyc++;
            end
        end
        bus_a.in_valid = 1'b0;
        start_a = 1'b0;
        if (done_cyc == 0) check("done_timeout_a", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d, l, x, cyc;
        bus_a.in_valid = 1'b0; bus_a.true_val = 1'b0; bus_a.false_val = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.true_val = 1'b0; bus_b.false_val = 1'b0;
        bus_c.in_valid = 1'b0; bus_c.true_val = 1'b0; bus_c.false_val = 1'b0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_err", err_a, 0);
        check("rst_fidx", fidx_a, 0);
        check("rst_ready", bus_a.in_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // in_ready stays low in IDLE even with valid offered
        bus_a.in_valid = 1'b1; bus_a.true_val = 1'b1;
        #1 check("idle_ready", bus_a.in_ready, 0);
        @(posedge clk); #1 bus_a.in_valid = 1'b0;

        // All-good run
        run_a(16'hFFFF, 16'h0000, 1, 0, d, l, x);
        check("t1_done_cyc", d, 17);
        check("t1_xfers", x, 16);
        check("t1_done", done_a, 1);
        check("t1_busy", busy_a, 0);
        check("t1_ready_done", bus_a.in_ready, 0);
        check("t1_pass", pass_a, 1);
        check("t1_err", err_a, 0);
        check("t1_fidx", fidx_a, 16);
        @(posedge clk); #1;
        check("t1_done_pulse", done_a, 0);
        check("t1_pass_held", pass_a, 1);

        // Single error at index 5
        run_a(16'hFFDF, 16'h0000, 1, 0, d, l, x);
        check("t2_done_cyc", d, 17);
        check("t2_pass", pass_a, 0);
        check("t2_err", err_a, 1);
        check("t2_fidx", fidx_a, 5);
        @(posedge clk); #1;

        // valid every 3rd cycle, false_val errors at 3 and 9
        run_a(16'hFFFF, 16'h0208, 3, 0, d, l, x);
        check("t3_xfers", x, 16);
        check("t3_last_xfer", l, 46);
        check("t3_done_cyc", d, 47);
        check("t3_err", err_a, 2);
        check("t3_fidx", fidx_a, 3);
        check("t3_pass", pass_a, 0);

        // start during DONE is ignored
        start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        check("done_start_ignored", busy_a, 0);
        @(posedge clk); #1;

        // start pulsed mid-run is ignored
        run_a(16'hFFFF, 16'h0000, 1, 5, d, l, x);
        check("t6_done_cyc", d, 17);
        check("t6_xfers", x, 16);
        check("t6_pass", pass_a, 1);
        // start in the cycle after DONE; error only on the final transfer
        @(posedge clk); #1;
        run_a(16'h7FFF, 16'h0000, 1, 0, d, l, x);
        check("t6b_done_cyc", d, 17);
        check("t6b_pass", pass_a, 0);
        check("t6b_err", err_a, 1);
        check("t6b_fidx", fidx_a, 15);
        @(posedge clk); #1;

        // Reset mid-run at idx 7
        start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus_a.in_valid = 1'b1; bus_a.true_val = 1'b0; bus_a.false_val = 1'b1;
            @(posedge clk); #1;
        end
        check("t5_err_before", err_a, 7);
        check("t5_busy_before", busy_a, 1);
        rst = 1'b1;
        #1;
        check("t5_busy", busy_a, 0);
        check("t5_ready", bus_a.in_ready, 0);
        check("t5_err", err_a, 0);
        check("t5_fidx", fidx_a, 0);
        check("t5_pass", pass_a, 0);
        check("t5_done", done_a, 0);
        bus_a.in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        run_a(16'hFFFF, 16'h0000, 1, 0, d, l, x);
        check("t5_rerun_done_cyc", d, 17);
        check("t5_rerun_xfers", x, 16);
        check("t5_rerun_pass", pass_a, 1);
        check("t5_rerun_err", err_a, 0);

        // Saturation with ERR_W=2
        bus_b.in_valid = 1'b1; bus_b.true_val = 1'b0; bus_b.false_val = 1'b1;
        start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        cyc = 1;
        while (!done_b && cyc < 40) begin
            @(posedge clk); #1 cyc++;
        end
        bus_b.in_valid = 1'b0;
        check("t4_done", done_b, 1);
        check("t4_done_cyc", cyc, 17);
        check("t4_err_sat", err_b, 3);
        check("t4_pass", pass_b, 0);
        check("t4_fidx", fidx_b, 0);

        // SAMPLES=1: good then bad
        bus_c.in_valid = 1'b1; bus_c.true_val = 1'b1; bus_c.false_val = 1'b0;
        start_c = 1'b1;
        @(posedge clk); #1 start_c = 1'b0;
        cyc = 1;
        while (!done_c && cyc < 10) begin
            @(posedge clk); #1 cyc++;
        end
        check("s1_done_cyc", cyc, 2);
        check("s1_pass", pass_c, 1);
        check("s1_fidx", fidx_c, 1);
        @(posedge clk); #1;
        bus_c.true_val = 1'b0;
        start_c = 1'b1;
        @(posedge clk); #1 start_c = 1'b0;
        cyc = 1;
        while (!done_c && cyc < 10) begin
            @(posedge clk); #1 cyc++;
        end
        bus_c.in_valid = 1'b0;
        check("s1b_done_cyc", cyc, 2);
        check("s1b_pass", pass_c, 0);
        check("s1b_err", err_c, 1);
        check("s1b_fidx", fidx_c, 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
